// File: rtl/xbar_pkg.sv
// Shared helpers for the crossbar target-side responder.
package xbar_pkg;

    // $clog2 that never yields a zero-width field (clog2_safe(1) == 1).
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/responder_fifo.sv
// In-order circular buffer, any depth >= 1; head data comes straight from storage flops.
// Push and pop in one cycle are both honoured, even when full; callers must never push a full FIFO without popping.
module responder_fifo
    import xbar_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = clog2_safe(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  usage_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  usage_q, usage_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (usage_q == '0);
    assign full_o  = (usage_q == CntW'(Depth));
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   usage_d = usage_q + CntW'(1);
            2'b01:   usage_d = usage_q - CntW'(1);
            default: usage_d = usage_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !pop_i))
        else $error("responder_fifo: push into full FIFO");

endmodule

// File: rtl/xbar_target_responder.sv
// Crossbar target endpoint: issues tagged requests to a fixed-latency bank, returns tagged read data in order.
// Response visible MemLatency+1 cycles after accept; credits stall requests so back-pressured responses are never dropped.
module xbar_target_responder
    import xbar_pkg::*;
#(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned MemLatency    = 1,
    parameter int unsigned FifoDepth     = 2,
    localparam int unsigned NumInLog     = clog2_safe(NumIn)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [NumInLog-1:0]      req_ini_addr_i,
    input  logic [ReqDataWidth-1:0]  req_wdata_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [NumInLog-1:0]      resp_ini_addr_o,
    output logic [RespDataWidth-1:0] resp_rdata_o,
    output logic                     mem_req_o,
    output logic [ReqDataWidth-1:0]  mem_wdata_o,
    input  logic [RespDataWidth-1:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef logic [NumInLog-1:0]      ini_addr_t;
    typedef logic [RespDataWidth-1:0] rdata_t;
    typedef struct packed {
        ini_addr_t ini_addr;
        rdata_t    rdata;
    } resp_entry_t;
    typedef struct packed {
        logic      vld;
        ini_addr_t ini_addr;
    } tag_stage_t;

    if (FifoDepth < 1 || MemLatency < 1) begin : g_bad_params
        $fatal(1, "xbar_target_responder: FifoDepth and MemLatency must both be >= 1");
    end

    logic [CntW-1:0] outstanding_q, outstanding_d;
    tag_stage_t      tag_q [MemLatency];
    tag_stage_t      tag_d [MemLatency];
    resp_entry_t     fifo_in, fifo_out;
    logic            fifo_push, fifo_full, fifo_empty, resp_hs;
    logic [CntW-1:0] fifo_usage;

    // Credits cover both accesses still in the bank and entries parked in the FIFO.
    assign req_ready_o  = !rst_i && (outstanding_q < CntW'(FifoDepth));
    assign mem_req_o    = req_valid_i && req_ready_o;
    assign mem_wdata_o  = req_wdata_i;
    assign resp_valid_o = !fifo_empty && !rst_i;
    assign resp_hs      = resp_valid_o && resp_ready_i;

    always_comb begin
        outstanding_d = outstanding_q;
        if (mem_req_o && !resp_hs) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!mem_req_o && resp_hs) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
    end

    always_comb begin
        tag_d[0] = '{vld: mem_req_o, ini_addr: req_ini_addr_i};
        for (int i = 1; i < int'(MemLatency); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            tag_q         <= '{default: '0};
        end else begin
            outstanding_q <= outstanding_d;
            tag_q         <= tag_d;
        end
    end

    assign fifo_push        = tag_q[MemLatency-1].vld;
    assign fifo_in.ini_addr = tag_q[MemLatency-1].ini_addr;
    assign fifo_in.rdata    = mem_rdata_i;

    responder_fifo #(
        .Depth (FifoDepth),
        .Width ($bits(resp_entry_t))
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (resp_hs),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage)
    );

    assign resp_ini_addr_o = fifo_out.ini_addr;
    assign resp_rdata_o    = fifo_out.rdata;

    a_credit_covers_fifo: assert property (@(posedge clk_i) disable iff (rst_i)
        (fifo_usage <= outstanding_q) && (!fifo_full || outstanding_q == CntW'(FifoDepth)))
        else $error("xbar_target_responder: credit counter out of step with FIFO");

endmodule
